// File: rtl/button_pkg.sv
// ---------------------------------------------------------------------------
// button_pkg
//   Shared definitions for the push-button debouncer array.
//   - idxw(): index width for an n-entry encoder, never less than 1 bit.
//   - DEF_*: filter and auto-repeat timing for the 50 MHz board clock
//     (2^16 cycles ~ 1.3 ms filter, 0.5 s first repeat, 0.1 s repeat rate).
//   - UP/DOWN/LEFT/RIGHT/START: channel index of each physical button.
// ---------------------------------------------------------------------------
package button_pkg;

    localparam int DEF_CNT        = 16;
    localparam int DEF_REP_DELAY  = 25_000_000;
    localparam int DEF_REP_PERIOD = 5_000_000;

    localparam int UP    = 0;
    localparam int DOWN  = 1;
    localparam int LEFT  = 2;
    localparam int RIGHT = 3;
    localparam int START = 4;

    function automatic int idxw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
//   One active-low push-button: two-flop synchroniser, saturating mismatch
//   counter, debounced level and registered press/release strobes.
//   Optional auto-repeat (macro BUTTON_DEBOUNCER_REPEAT_EN): a hold counter
//   produces a repeat strobe REP_DELAY cycles after the press strobe, then
//   every REP_PERIOD cycles while the key stays down. Without the macro the
//   repeat outputs are tied low and no hold counter exists.
//
//   Ports
//     clk_i      clock
//     rst_ni     asynchronous active-low reset
//     key_ni     raw button, active-low, asynchronous
//     state_o    debounced level, 1 = pressed
//     down_o     1-cycle press strobe
//     up_o       1-cycle release strobe
//     rep_o      1-cycle auto-repeat strobe
//     down_d_o   next-cycle value of down_o (for same-cycle encoders)
//     rep_d_o    next-cycle value of rep_o
// ---------------------------------------------------------------------------
module debounce_channel
    import button_pkg::*;
#(
    parameter int CNT        = DEF_CNT,
    parameter int REP_DELAY  = DEF_REP_DELAY,
    parameter int REP_PERIOD = DEF_REP_PERIOD
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_ni,
    output logic state_o,
    output logic down_o,
    output logic up_o,
    output logic rep_o,
    output logic down_d_o,
    output logic rep_d_o
);

    if (CNT < 1 || REP_DELAY < 2 || REP_PERIOD < 2) begin : g_cfg_check
        $error("debounce_channel: CNT must be >= 1, REP_DELAY and REP_PERIOD >= 2");
    end

    logic [1:0]     sync_q, sync_d;
    logic [CNT-1:0] cnt_q, cnt_d;
    logic           state_q, state_d;
    logic           down_q, down_d;
    logic           up_q, up_d;
    logic           mismatch;
    logic           toggle;

    // The level only flips after 2^CNT consecutive disagreeing samples; any
    // agreeing sample in between clears the count and restarts the interval.
    assign mismatch = state_q ^ sync_q[1];
    assign toggle   = mismatch & (&cnt_q);

    always_comb begin
        sync_d  = {sync_q[0], ~key_ni};
        cnt_d   = '0;
        if (mismatch && !toggle) begin
            cnt_d = cnt_q + 1'b1;
        end
        state_d = state_q ^ toggle;
        down_d  = toggle & ~state_q;
        up_d    = toggle & state_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            state_q <= 1'b0;
            down_q  <= 1'b0;
            up_q    <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            down_q  <= down_d;
            up_q    <= up_d;
        end
    end

`ifdef BUTTON_DEBOUNCER_REPEAT_EN
    localparam int HOLD_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int HW       = $clog2(HOLD_MAX);
    localparam logic [HW-1:0] DELAY_TERM  = HW'(REP_DELAY - 1);
    localparam logic [HW-1:0] PERIOD_TERM = HW'(REP_PERIOD - 1);

    logic [HW-1:0] hold_q, hold_d;
    logic          phase_q, phase_d;   // 0: waiting for first repeat, 1: periodic
    logic          rep_q, rep_d;
    logic          hold_end;

    // hold_q reads k in the k-th cycle after the press strobe cycle (0 on the
    // strobe cycle itself, since it is held clear while the level is 0), so
    // the strobe registered at hold_q == DELAY_TERM lands exactly REP_DELAY
    // cycles after the press strobe. The counter then restarts per period.
    assign hold_end = phase_q ? (hold_q == PERIOD_TERM) : (hold_q == DELAY_TERM);

    always_comb begin
        hold_d  = '0;
        phase_d = 1'b0;
        rep_d   = 1'b0;
        // A releasing toggle clears the counter and suppresses the strobe,
        // so a repeat never shares a cycle with the release strobe.
        if (state_q && !toggle) begin
            if (hold_end) begin
                rep_d   = 1'b1;
                phase_d = 1'b1;
            end else begin
                hold_d  = hold_q + 1'b1;
                phase_d = phase_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q  <= '0;
            phase_q <= 1'b0;
            rep_q   <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            phase_q <= phase_d;
            rep_q   <= rep_d;
        end
    end

    assign rep_o   = rep_q;
    assign rep_d_o = rep_d;
`else
    assign rep_o   = 1'b0;
    assign rep_d_o = 1'b0;
`endif

    assign state_o  = state_q;
    assign down_o   = down_q;
    assign up_o     = up_q;
    assign down_d_o = down_d;

endmodule

// File: rtl/button_debouncer_array.sv
// ---------------------------------------------------------------------------
// button_debouncer_array
//   N independent active-low push-button debouncers plus a "last pressed key"
//   register. Optional auto-repeat is enabled with macro
//   BUTTON_DEBOUNCER_REPEAT_EN; repeats then also update the last-key
//   register.
//
//   Ports
//     clk        system clock
//     rst        asynchronous active-low reset
//     key        raw buttons, active-low (0 = pressed)
//     key_state  debounced levels, 1 = pressed
//     key_down   1-cycle press strobes
//     key_up     1-cycle release strobes
//     key_rep    1-cycle auto-repeat strobes (0 without the macro)
//     last_idx   lowest index among the most recent press/repeat strobes
//     last_vld   1-cycle strobe in the cycle last_idx takes a new value
// ---------------------------------------------------------------------------
module button_debouncer_array
    import button_pkg::*;
#(
    parameter int N          = 4,
    parameter int CNT        = DEF_CNT,
    parameter int REP_DELAY  = DEF_REP_DELAY,
    parameter int REP_PERIOD = DEF_REP_PERIOD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         key,
    output logic [N-1:0]         key_state,
    output logic [N-1:0]         key_down,
    output logic [N-1:0]         key_up,
    output logic [N-1:0]         key_rep,
    output logic [idxw(N)-1:0]   last_idx,
    output logic                 last_vld
);

    localparam int IDXW = idxw(N);

    logic [N-1:0]    down_d;
    logic [N-1:0]    rep_d;
    logic [N-1:0]    event_d;
    logic [IDXW-1:0] last_idx_q, last_idx_d;
    logic            last_vld_q, last_vld_d;

    for (genvar gi = 0; gi < N; gi++) begin : g_ch
        debounce_channel #(
            .CNT        (CNT),
            .REP_DELAY  (REP_DELAY),
            .REP_PERIOD (REP_PERIOD)
        ) u_ch (
            .clk_i    (clk),
            .rst_ni   (rst),
            .key_ni   (key[gi]),
            .state_o  (key_state[gi]),
            .down_o   (key_down[gi]),
            .up_o     (key_up[gi]),
            .rep_o    (key_rep[gi]),
            .down_d_o (down_d[gi]),
            .rep_d_o  (rep_d[gi])
        );
    end

    // Encode from the channels' next-state strobes so the register updates
    // on the same edge that raises the strobe itself.
    assign event_d = down_d | rep_d;

    // Scan from the top down so the lowest active index is the last to write.
    always_comb begin
        last_idx_d = last_idx_q;
        last_vld_d = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (event_d[i]) begin
                last_idx_d = IDXW'(i);
                last_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_idx_q <= '0;
            last_vld_q <= 1'b0;
        end else begin
            last_idx_q <= last_idx_d;
            last_vld_q <= last_vld_d;
        end
    end

    assign last_idx = last_idx_q;
    assign last_vld = last_vld_q;

endmodule

// File: tb/tb_button_debouncer_array.sv
// ---------------------------------------------------------------------------
// tb_button_debouncer_array
//   Reference model: a button's level flips when the synchronised samples
//   (raw samples delayed two edges) of the last 2^CNT edges all disagree with
//   the current level. Repeats are computed from the elapsed cycles since the
//   press strobe. The model pushes the expected output word per edge; a
//   monitor on the falling edge pops and compares it against the DUT.
// ---------------------------------------------------------------------------
module tb_button_debouncer_array;

    localparam int N    = 4;
    localparam int CNT  = 4;
    localparam int RD   = 20;
    localparam int RP   = 8;
    localparam int WIN  = 1 << CNT;
    localparam int IDXW = 2;
    localparam int W    = 4 * N + IDXW + 1;

    logic            clk;
    logic            rst;
    logic [N-1:0]    key;
    logic [N-1:0]    key_state;
    logic [N-1:0]    key_down;
    logic [N-1:0]    key_up;
    logic [N-1:0]    key_rep;
    logic [IDXW-1:0] last_idx;
    logic            last_vld;

    int n_tests;
    int n_fail;

    button_debouncer_array #(
        .N          (N),
        .CNT        (CNT),
        .REP_DELAY  (RD),
        .REP_PERIOD (RP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key       (key),
        .key_state (key_state),
        .key_down  (key_down),
        .key_up    (key_up),
        .key_rep   (key_rep),
        .last_idx  (last_idx),
        .last_vld  (last_vld)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    logic [W-1:0]  exp_q[$];
    bit   [N-1:0]  hist[$];      // hist[k] = pressed-sample taken k edges ago
    bit   [N-1:0]  m_lvl;
    int            m_cyc;
    int            m_dtime[N];
    bit [IDXW-1:0] m_idx;

    always @(posedge clk) begin : model_p
        bit [N-1:0] dn, up, rp, ev;
        bit         vld;
        bit         all_diff;
        int         el;
        dn = '0; up = '0; rp = '0; vld = 1'b0;
        if (!rst) begin
            hist.delete();
            for (int k = 0; k < WIN + 2; k++) hist.push_back('0);
            m_lvl = '0;
            m_idx = '0;
            m_cyc = 0;
        end else begin
            m_cyc++;
            hist.push_front(~key);
            void'(hist.pop_back());
            for (int i = 0; i < N; i++) begin
                all_diff = 1'b1;
                for (int k = 2; k < WIN + 2; k++) begin
                    if (hist[k][i] == m_lvl[i]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_lvl[i] = ~m_lvl[i];
                    if (m_lvl[i]) begin
                        dn[i] = 1'b1;
                        m_dtime[i] = m_cyc;
                    end else begin
                        up[i] = 1'b1;
                    end
                end
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
                if (m_lvl[i] && !dn[i]) begin
                    el = m_cyc - m_dtime[i];
                    if (el == RD || (el > RD && (el - RD) % RP == 0)) rp[i] = 1'b1;
                end
`endif
            end
            ev = dn | rp;
            for (int i = N - 1; i >= 0; i--) begin
                if (ev[i]) begin
                    m_idx = i[IDXW-1:0];
                    vld = 1'b1;
                end
            end
        end
        if (!rst) exp_q.push_back('0);
        else      exp_q.push_back({m_lvl, dn, up, rp, m_idx, vld});
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : monitor_p
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {key_state, key_down, key_up, key_rep, last_idx, last_vld};
            n_tests++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL outputs t=%0t {state,down,up,rep,idx,vld}: got %b_%b_%b_%b_%b_%b required %b_%b_%b_%b_%b_%b",
                         $time, act_v[W-1 -: N], act_v[W-N-1 -: N], act_v[W-2*N-1 -: N],
                         act_v[W-3*N-1 -: N], act_v[IDXW:1], act_v[0],
                         exp_v[W-1 -: N], exp_v[W-N-1 -: N], exp_v[W-2*N-1 -: N],
                         exp_v[W-3*N-1 -: N], exp_v[IDXW:1], exp_v[0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int got, input int req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    function automatic int out_word();
        return int'({key_state, key_down, key_up, key_rep, last_idx, last_vld});
    endfunction

    // ---------------- stimulus ----------------
    initial begin : stim_p
        int seen;
        int cnt_dn;
        int got_idx;
        int got_vld;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0;
        key = '1;
        step(3);
        check("reset_outputs", out_word(), 0);
        rst = 1'b1;

        // idle, all released
        step(40);

        // single press: latency, last-key, strobe width
        key[2] = 1'b0;
        seen = 0; cnt_dn = 0; got_idx = -1; got_vld = -1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (key_down[2]) begin
                cnt_dn++;
                if (seen == 0) begin
                    seen = n;
                    got_idx = int'(last_idx);
                    got_vld = int'(last_vld);
                end
            end
        end
        #1;
        check("press_latency_edges", seen, WIN + 2);
        check("press_last_idx", got_idx, 2);
        check("press_last_vld", got_vld, 1);
        check("press_strobe_cycles", cnt_dn, 1);
        key[2] = 1'b1;
        step(25);
        check("release_level", int'(key_state[2]), 0);

        // glitch restarts the filter
        key[1] = 1'b0; step(10);
        key[1] = 1'b1; step(1);
        key[1] = 1'b0; step(30);
        check("glitch_then_held_level", int'(key_state[1]), 1);
        key[1] = 1'b1; step(25);

        // simultaneous press, lowest index wins; partial release
        key[0] = 1'b0; key[3] = 1'b0;
        step(25);
        check("dual_last_idx", int'(last_idx), 0);
        key[0] = 1'b1;
        step(25);
        check("key3_still_held", int'(key_state[3]), 1);
        check("key0_released", int'(key_state[0]), 0);
        key[3] = 1'b1;
        step(25);

        // long hold (repeat strobes when enabled), then release
        key[1] = 1'b0; step(70);
        key[1] = 1'b1; step(30);

        // reset mid-hold and mid-count, keys kept low through reset release
        key[1] = 1'b0; step(40);
        key[2] = 1'b0; step(8);
        rst = 1'b0;
        #1;
        check("reset_mid_outputs", out_word(), 0);
        step(2);
        rst = 1'b1;
        step(30);
        check("repress_after_reset", int'(key_state[2:1]), 3);
        key = '1;
        step(25);

        // random toggling: mix of glitches and holds
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 99) < 5) key[i] = ~key[i];
            end
            step(1);
        end
        key = '1;
        step(30);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/button_debouncer_array.md
Name: button_debouncer_array

Overview:
- Multi-channel successor to the single-key debouncer.
- Debounces N active-low push-buttons (snake direction pad plus start/pause) in one clock domain.
- Per channel it produces a level, press and release strobes, and an optional hold-to-repeat strobe.
- It also keeps a "last pressed key" register, so the game controller can latch a direction without scanning all strobes.

Parameters:
- N, 4, number of button channels (1..16).
- CNT, 16, debounce counter width; the filter interval is 2^CNT cycles.
- REP_DELAY, 25_000_000, cycles a key must be held after its press before the first repeat strobe (>=2).
- REP_PERIOD, 5_000_000, cycles between subsequent repeat strobes (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset. All state clears while low.
- key  in  N  raw buttons, asynchronous, active-low (0 = pressed).
- key_state  out  N  debounced level, 1 = pressed.
- key_down  out  N  1-cycle strobe on debounced press.
- key_up  out  N  1-cycle strobe on debounced release.
- key_rep  out  N  1-cycle auto-repeat strobe while held.
- last_idx  out  IDXW  index of the most recent key_down; IDXW = max(1, clog2(N)).
- last_vld  out  1  1-cycle strobe, asserted the same cycle that last_idx is updated.

Behaviour:
- Reset: every output is 0, all synchronisers are 0 (not pressed), all counters are 0. Every register, strobes included, uses the async reset.
- Sync: per channel, sr <= {sr[0], ~key[i]}. The synced level is sr[1].
- Filter: per channel, mismatch = (key_state[i] != sr[1]).
  - If mismatch and count != all-ones: count increments.
  - If mismatch and count == all-ones: key_state toggles and count wraps to 0.
  - If no mismatch: count is cleared to 0.
  - Any glitch shorter than 2^CNT cycles is rejected fully and restarts the count.
- Latency: key first sampled low at edge E0 -> key_state=1 after edge E0+2^CNT+1. Release is symmetric.
- Strobes are registered on the toggle edge:
  - key_down=1 for exactly the cycle in which key_state first reads 1.
  - key_up=1 for exactly the cycle in which key_state first reads 0.
- Last-key register:
  - If any key_down is 1, last_idx <= lowest index i with key_down[i]=1, and last_vld=1 in the same cycle.
  - Otherwise last_idx holds and last_vld=0.
  - Simultaneous presses: the lowest index wins. Higher-index presses are still reported on key_down.
- Channels are fully independent. No cross-channel lockout.
- Reset mid-operation: counters and levels clear immediately. A key held through reset release is treated as a new press and reports key_down after the full filter interval.

Optional Feature:
- Macro: BUTTON_DEBOUNCER_REPEAT_EN.
- Defined: each channel has a hold counter, cleared while key_state=0 and on the key_down cycle.
  - key_rep pulses at REP_DELAY cycles after key_down, then every REP_PERIOD cycles while held.
  - On release, the hold counter clears that cycle and no further key_rep is issued.
  - key_rep never coincides with key_down or key_up.
  - key_rep also updates last_idx/last_vld with the same lowest-index priority, considering (key_down | key_rep).
- Undefined: key_rep is tied to 0 and no hold counters are generated.

Decomposition:
- Shared package button_pkg:
  - IDXW function (clog2 with minimum 1).
  - Default CNT/REP_DELAY/REP_PERIOD constants for the 50 MHz board clock.
  - Button index localparams: UP, DOWN, LEFT, RIGHT, START.
- Sub-module debounce_channel, one per key via generate:
  - Holds the synchroniser, filter counter, level, strobes and the macro-gated hold counter.
- Top level contains only the generate loop and the priority encoder/last-key register.

Test Plan:
- N=4, CNT=4, reset low then high: all outputs 0. Hold key=4'hF for 40 cycles -> no strobes.
- key[2] driven low at edge E0 -> key_state[2]=1 and key_down[2]=1 exactly after edge E0+17. last_idx=2 and last_vld=1 in that same cycle. key_down is 1 for one cycle only.
- key[1] low for 10 cycles, high for 1 cycle, low again -> key_state stays 0 until 17 edges after the final low sample. key_up is never asserted.
- key[0] and key[3] low on the same edge -> both key_down strobes in the same cycle, last_idx=0. Release key[0] only -> key_up[0] after 17 edges, and key_state[3] stays 1.
- Press held, rst pulsed low mid-count and mid-hold -> outputs 0 immediately. After rst is released with the key still low, key_down asserts 17 edges after the first post-reset sample.
- Macro defined, REP_DELAY=20, REP_PERIOD=8, key[1] held -> key_rep[1] at key_down+20, +28, +36. Release -> no key_rep after the release edge. Macro undefined -> key_rep stays 0 throughout.
